// File: rtl/regwr_strobe.sv
// Host write-strobe generator: pairs 16-bit high/low host writes into 32-bit
// words and drives a shared data bus plus a one-cycle one-hot enable per slot.
module regwr_strobe #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            sys_clk_i,
  input  logic            reset_i,
  input  logic            wr_req_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic            wr_half_i,
  input  logic [15:0]     wr_data_i,
  output logic            wr_ack_o,
  output logic            busy_o,
  output logic [31:0]     reg_d_o,
  output logic [NREG-1:0] reg_en_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPT = 3'd1;
  localparam logic [2:0] S_STRB = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam logic [AW:0] NREG_W = NREG[AW:0];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic          cap_half_q, cap_half_d;
  logic [15:0]   cap_data_q, cap_data_d;
  logic [15:0]   hi_hold_q, hi_hold_d;
  logic [31:0]   reg_d_q, reg_d_d;
  logic          in_range;

  assign in_range = ({1'b0, cap_addr_q} < NREG_W);

  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cap_half_d = cap_half_q;
    cap_data_d = cap_data_q;
    hi_hold_d  = hi_hold_q;
    reg_d_d    = reg_d_q;
    case (state_q)
      S_IDLE: if (wr_req_i) begin
        state_d    = S_CAPT;
        cap_addr_d = wr_addr_i;
        cap_half_d = wr_half_i;
        cap_data_d = wr_data_i;
      end
      S_CAPT: begin
        if (cap_half_q) begin
          hi_hold_d = cap_data_q;
          state_d   = S_ACK;
        end else if (in_range) begin
          reg_d_d = {hi_hold_q, cap_data_q};
          state_d = S_STRB;
        end else begin
          state_d = S_ACK;
        end
      end
      S_STRB:  state_d = S_ACK;
      S_ACK:   state_d = S_REL;
      // Wait for the requester to let go so a held request is not re-accepted.
      S_REL:   if (!wr_req_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cap_addr_q <= '0;
      cap_half_q <= 1'b0;
      cap_data_q <= '0;
      hi_hold_q  <= '0;
      reg_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cap_half_q <= cap_half_d;
      cap_data_q <= cap_data_d;
      hi_hold_q  <= hi_hold_d;
      reg_d_q    <= reg_d_d;
    end
  end

  always_comb begin
    reg_en_o = '0;
    for (int i = 0; i < NREG; i++)
      reg_en_o[i] = (state_q == S_STRB) && (cap_addr_q == i[AW-1:0]);
  end

  assign wr_ack_o = (state_q == S_ACK);
  assign busy_o   = (state_q != S_IDLE);
  assign reg_d_o  = reg_d_q;

endmodule

// File: tb/tb_regwr_strobe.sv
// Bench for regwr_strobe: scoreboard of expected strobes (slot, word) checked
// by a monitor, plus scenario tasks for reset, pairing, range and timing.
module tb_regwr_strobe;

  typedef struct {
    logic [7:0]  en;
    logic [31:0] d;
  } exp_t;

  logic        clk, reset;
  logic        a_req, a_half, a_ack, a_busy;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic [31:0] a_d;
  logic [7:0]  a_en;
  logic        b_req, b_half, b_ack, b_busy;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  logic [31:0] b_d;
  logic [5:0]  b_en;

  int   total, bad, cyc, last_pulse;
  bit   mon_on;
  exp_t sb[$];
  int   pulse_q[$];
  logic [15:0] exp_hi;
  logic [31:0] exp_d;

  regwr_strobe #(.NREG(8), .AW(3)) dut_a (
    .sys_clk_i(clk), .reset_i(reset), .wr_req_i(a_req), .wr_addr_i(a_addr),
    .wr_half_i(a_half), .wr_data_i(a_data), .wr_ack_o(a_ack), .busy_o(a_busy),
    .reg_d_o(a_d), .reg_en_o(a_en));

  regwr_strobe #(.NREG(6), .AW(3)) dut_b (
    .sys_clk_i(clk), .reset_i(reset), .wr_req_i(b_req), .wr_addr_i(b_addr),
    .wr_half_i(b_half), .wr_data_i(b_data), .wr_ack_o(b_ack), .busy_o(b_busy),
    .reg_d_o(b_d), .reg_en_o(b_en));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe on dut_a must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_on && a_en !== 8'h00) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe en=%b d=%h", a_en, a_d);
      end else begin
        e = sb.pop_front();
        if (a_en !== e.en || a_d !== e.d) begin
          bad++;
          $display("FAIL strobe got en=%b d=%h want en=%b d=%h", a_en, a_d, e.en, e.d);
        end
      end
      if (a_ack !== 1'b0) begin
        bad++;
        $display("FAIL ack_with_strobe ack=%b want 0", a_ack);
      end
      last_pulse = cyc;
      pulse_q.push_back(cyc);
    end
  end

  task automatic write_a(input logic [2:0] addr, input logic half, input logic [15:0] data);
    exp_t e;
    bit   strobed, got;
    int   ack_cyc;
    strobed = 0;
    got     = 0;
    ack_cyc = 0;
    if (half) exp_hi = data;
    else begin
      exp_d   = {exp_hi, data};
      strobed = 1;
      e.en    = 8'(1) << addr;
      e.d     = exp_d;
      sb.push_back(e);
    end
    a_addr = addr; a_half = half; a_data = data; a_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) begin got = 1; ack_cyc = cyc; end
    end
    a_req = 0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout addr=%0d got none want 1 ack", addr);
    end else if (strobed) begin
      total++;
      if (last_pulse !== ack_cyc - 1) begin
        bad++;
        $display("FAIL strobe_to_ack pulse_cyc=%0d want %0d", last_pulse, ack_cyc - 1);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_strobe pending=%0d want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    total++;
    if (a_ack !== 1'b0) begin
      bad++;
      $display("FAIL double_ack ack=%b want 0", a_ack);
    end
    @(negedge clk);
    total++;
    if (a_d !== exp_d) begin
      bad++;
      $display("FAIL reg_d_after_write got %h want %h", a_d, exp_d);
    end
  endtask

  task automatic test_reset;
    bit got;
    reset = 1;
    a_req = 1; a_addr = 3'd2; a_half = 1; a_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    mon_on = 1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (a_en !== 8'h00 || a_ack !== 1'b0 || a_busy !== 1'b0 || a_d !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs en=%b ack=%b busy=%b d=%h want all 0", a_en, a_ack, a_busy, a_d);
      end
      total++;
      if (b_en !== 6'h00 || b_ack !== 1'b0 || b_busy !== 1'b0 || b_d !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs_b en=%b ack=%b busy=%b d=%h want all 0", b_en, b_ack, b_busy, b_d);
      end
      if (i == 0) @(negedge clk);
    end
    reset = 0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL first_capture busy=%b want 1", a_busy);
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) got = 1;
    end
    a_req = 0;
    exp_hi = 16'h1234;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL reset_release_ack got none want 1 ack");
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (a_d !== 32'h0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL high_write_no_dbus d=%h busy=%b want 0/0", a_d, a_busy);
    end
  endtask

  task automatic test_paired;
    write_a(3'd2, 1'b1, 16'h1234);
    write_a(3'd2, 1'b0, 16'hABCD);
    total++;
    if (a_d !== 32'h1234ABCD) begin
      bad++;
      $display("FAIL paired_word got %h want 1234abcd", a_d);
    end
  endtask

  task automatic test_low_only;
    write_a(3'd5, 1'b0, 16'h0055);
    total++;
    if (a_d !== 32'h12340055) begin
      bad++;
      $display("FAIL low_reuse_hi got %h want 12340055", a_d);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    exp_hi = 16'h0; exp_d = 32'h0;
    write_a(3'd0, 1'b0, 16'h0001);
    total++;
    if (a_d !== 32'h00000001) begin
      bad++;
      $display("FAIL low_after_reset got %h want 00000001", a_d);
    end
  endtask

  task automatic test_oor;
    bit got, seen;
    logic [5:0] en_seen;
    got = 0; seen = 0; en_seen = '0;
    b_addr = 3'd3; b_half = 0; b_data = 16'h5A5A; b_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_en !== 6'h00) begin seen = 1; en_seen = b_en; end
      if (b_ack === 1'b1) got = 1;
    end
    b_req = 0;
    total++;
    if (!seen || en_seen !== 6'b001000 || !got) begin
      bad++;
      $display("FAIL b_inrange en=%b ack=%b want en=001000 ack=1", en_seen, got);
    end
    total++;
    if (b_d !== 32'h00005A5A) begin
      bad++;
      $display("FAIL b_inrange_d got %h want 00005a5a", b_d);
    end
    @(negedge clk);
    @(negedge clk);
    got = 0;
    b_addr = 3'd7; b_half = 0; b_data = 16'h7777; b_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      total++;
      if (b_en !== 6'h00) begin
        bad++;
        $display("FAIL oor_strobe en=%b want 0", b_en);
      end
      if (b_ack === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL oor_ack got none want 1 ack");
    end
    total++;
    if (b_d !== 32'h00005A5A) begin
      bad++;
      $display("FAIL oor_d got %h want 00005a5a", b_d);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (b_busy !== 1'b1 || b_ack !== 1'b0 || b_en !== 6'h00) begin
        bad++;
        $display("FAIL held_req busy=%b ack=%b en=%b want 1/0/0", b_busy, b_ack, b_en);
      end
    end
    b_req = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL release_idle busy=%b want 0", b_busy);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit hit;
    write_a(3'd1, 1'b1, 16'h9999);
    e.en = 8'b0001_0000; e.d = 32'h99990042;
    sb.push_back(e);
    a_addr = 3'd4; a_half = 0; a_data = 16'h0042; a_req = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (a_en !== 8'h00) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_strobe_timeout got none want strobe");
      sb.delete();
    end
    reset = 1; a_req = 0;
    @(negedge clk);
    reset = 0;
    total++;
    if (a_en !== 8'h00 || a_ack !== 1'b0 || a_busy !== 1'b0 || a_d !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid en=%b ack=%b busy=%b d=%h want all 0", a_en, a_ack, a_busy, a_d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (a_ack !== 1'b0) begin
        bad++;
        $display("FAIL dropped_ack ack=%b want 0", a_ack);
      end
    end
    exp_hi = 16'h0; exp_d = 32'h0;
    write_a(3'd6, 1'b0, 16'h0003);
    total++;
    if (a_d !== 32'h00000003) begin
      bad++;
      $display("FAIL hi_hold_cleared got %h want 00000003", a_d);
    end
  endtask

  task automatic test_back_to_back;
    pulse_q.delete();
    for (int i = 0; i < 8; i++)
      write_a(3'(i), 1'b0, 16'h1000 + 16'(i));
    total++;
    if (pulse_q.size() != 8) begin
      bad++;
      $display("FAIL b2b_count got %0d want 8", pulse_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        total++;
        if (pulse_q[i] - pulse_q[i-1] != 5) begin
          bad++;
          $display("FAIL b2b_spacing idx=%0d got %0d want 5", i, pulse_q[i] - pulse_q[i-1]);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_pulse = -100; mon_on = 0;
    exp_hi = 16'h0; exp_d = 32'h0;
    a_req = 0; a_addr = 0; a_half = 0; a_data = 0;
    b_req = 0; b_addr = 0; b_half = 0; b_data = 0;
    reset = 1;
    test_reset;
    test_paired;
    test_low_only;
    test_oor;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regwr_strobe.md
# regwr_strobe

Bus-side write-strobe generator for the register banks built from `slatch` enable-capture cells. It accepts 16-bit host write cycles through a request/acknowledge handshake and pairs high/low halves into 32-bit words. For each completed low-half write it presents the word on a shared data bus with a one-cycle, one-hot enable pulse. It sits directly upstream of the slatch banks: `reg_d` drives their `d` inputs, `reg_en[i]` drives their `en` inputs, and both blocks run on the same `sys_clk`.

## Interface
- `NREG`, default 8: number of 32-bit register slots; one enable bit each.
- `AW`, default 3: register-select address width; `NREG` ≤ 2^`AW`.

- `sys_clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_req`  in  1  write request; held high by the requester until `wr_ack` is seen.
- `wr_addr`  in  AW  register select; stable while `wr_req` is high.
- `wr_half`  in  1  1 = high half [31:16], 0 = low half [15:0].
- `wr_data`  in  16  write data; stable while `wr_req` is high.
- `wr_ack`  out  1  one-cycle acceptance pulse.
- `busy`  out  1  high in every state except IDLE.
- `reg_d`  out  32  data to the slatch `d` inputs; holds its value between strobes.
- `reg_en`  out  NREG  one-hot enable pulse, at most one bit high, one cycle wide.

## Operation
- Internal registers: `cap_addr`, `cap_half`, `cap_data` (request capture), `hi_hold` [15:0] (last high half written), `reg_d`.
- State machine, five states:
  - IDLE: `wr_req`=1 → CAPT. Capture `wr_addr`, `wr_half`, `wr_data` on this edge.
  - CAPT, high half (`cap_half`=1): `hi_hold` ← `cap_data`; → ACK. No strobe.
  - CAPT, low half with `cap_addr` < NREG: `reg_d` ← {`hi_hold`, `cap_data`}; → STRB.
  - CAPT, low half with `cap_addr` ≥ NREG: → ACK. No strobe, `reg_d` unchanged.
  - STRB: `reg_en[cap_addr]`=1 for exactly this cycle; → ACK.
  - ACK: `wr_ack`=1 for exactly this cycle; → REL.
  - REL: `wr_req`=0 → IDLE; otherwise stay. This prevents a held request from being accepted twice.
- `hi_hold` is global, not per address. A low write pairs with the most recent high write to any address. `hi_hold` is not cleared by a low write, so repeated low writes reuse it.
- `wr_addr`/`wr_half`/`wr_data` are ignored outside the IDLE sampling edge.
- Reset values: state IDLE; `wr_ack`=0; `busy`=0; `reg_en`=0; `reg_d`=0x00000000; `hi_hold`=0x0000; `cap_*`=0.
- Reset asserted in any state takes priority:
  - next cycle is IDLE with all outputs at reset values;
  - a pending strobe or ack is dropped and never issued;
  - `hi_hold` is cleared.
- Reset and `wr_req` both high on one edge: reset wins and the request is not captured. It is captured on the first edge with `reset`=0 and `wr_req`=1.

## Timing
- Edge E0: IDLE samples `wr_req`=1.
- Low write in range: CAPT in cycle E0→E1. STRB in E1→E2, with `reg_en` high and `reg_d` already holding the new word (loaded at E1). The slatch loads at E2. ACK in E2→E3.
- High write, or out-of-range low write: CAPT then ACK. `wr_ack` is high in E1→E2.
- REL lasts at least one cycle. With a requester that drops `wr_req` at the edge after seeing ack, the next request is sampled no earlier than:
  - 5 edges after E0 for a strobed write;
  - 4 edges after E0 for an unstrobed write.
- `reg_d` is stable for the whole `reg_en` cycle and afterwards, until the next in-range low write.
- `reg_en` and `wr_ack` are never high in the same cycle.

## Test plan
- Reset: assert `reset` for 2 cycles with `wr_req`=1.
  - Required: `reg_en`=0, `wr_ack`=0, `busy`=0, `reg_d`=0 throughout.
  - Required: first capture occurs on the first edge after `reset` drops.
- Paired write: high 0x1234 to addr 2, then low 0xABCD to addr 2.
  - Required: `reg_en`=0b00000100 for one cycle with `reg_d`=0x1234ABCD.
  - Required: `wr_ack` one cycle later; exactly one ack per request.
- Low-only write: low 0x0055 to addr 5 after the previous test.
  - Required: `reg_d`=0x12340055 and `reg_en`=0b00100000.
  - Required: low 0x0001 to addr 0 with no high write after reset gives `reg_d`=0x00000001.
- Out-of-range and held request: NREG=6, low write to addr 7.
  - Required: `wr_ack` pulses, `reg_en` stays 0, `reg_d` unchanged.
  - With `wr_req` held high 10 cycles after ack: `busy`=1 and no second ack.
- Reset mid-operation: assert `reset` during STRB.
  - Required: `reg_en` low the next cycle, no `wr_ack` issued, `hi_hold` reads 0 on the following low write.
- Back-to-back: 8 low writes to addrs 0–7 with zero requester turnaround.
  - Required: 8 distinct one-hot pulses in address order.
  - Required: each pulse is 5 cycles after the previous one.
